// File: rtl/issue_sequencer_pkg.sv
// Shared opcode constants, bundle field positions and state/PC-select encodings
// for the dual-slot issue sequencer.
package issue_pkg;

  localparam logic [4:0] OP1_ALU  = 5'b01000;
  localparam logic [4:0] OP1_ADDI = 5'b00101;
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP2_LD   = 5'b01010;
  localparam logic [4:0] OP2_ST   = 5'b01011;
  localparam logic [4:0] OP2_JMP  = 5'b11110;
  localparam logic [4:0] OP2_BR   = 5'b11011;

  // Low-bit positions of each bundle field; rs2 is the low three bits of the slot-1 imm field
  localparam int OP1_LSB  = 0;
  localparam int IMM_LSB  = 5;
  localparam int RS2_LSB  = IMM_LSB;
  localparam int RD1_LSB  = 9;
  localparam int RS1_LSB  = 12;
  localparam int OP2_LSB  = 16;
  localparam int RD2_LSB  = 21;
  localparam int BASE_LSB = 24;
  localparam int OFFS_LSB = 27;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_BUBBLE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

endpackage

// File: rtl/issue_sequencer_if.sv
// Fetch handshake, data-memory handshake and datapath control strobes of the
// issue sequencer; master is the sequencer side, slave the surrounding datapath.
interface issue_sequencer_if
  import issue_pkg::*;
#(
  parameter int STALL_W = 16
);
  logic               ir_valid;
  logic [31:0]        ir;
  logic               ir_ready;
  logic               cond_true;
  logic               mem_ack;
  logic               mem_req;
  logic               mem_we;
  logic               commit1;
  logic               commit2;
  logic               pc_write;
  pc_src_e            pc_src;
  logic               flush;
  logic               mem_err;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    input  ir_valid, ir, cond_true, mem_ack,
    output ir_ready, mem_req, mem_we, commit1, commit2, pc_write, pc_src,
           flush, mem_err, stall_cnt
  );

  modport slave (
    output ir_valid, ir, cond_true, mem_ack,
    input  ir_ready, mem_req, mem_we, commit1, commit2, pc_write, pc_src,
           flush, mem_err, stall_cnt
  );
endinterface

// File: rtl/issue_sequencer_hazard_chk.sv
// Combinational hazard detection: load-use against the incoming bundle and
// slot-1 versus load destination conflict inside the held bundle.
module issue_hazard_chk
  import issue_pkg::*;
(
  input  logic       loadPend_i,
  input  logic [2:0] loadRd_i,
  input  logic [2:0] incRs1_i,
  input  logic [2:0] incRs2_i,
  input  logic [4:0] op2_i,
  input  logic [2:0] rd1_i,
  input  logic [2:0] rd2_i,
  output logic       loadUse_o,
  output logic       rdConflict_o
);

  assign loadUse_o    = loadPend_i && ((incRs1_i == loadRd_i) || (incRs2_i == loadRd_i));
  assign rdConflict_o = (op2_i == OP2_LD) && (rd1_i == rd2_i);

endmodule

// File: rtl/issue_sequencer.sv
// Dual-slot issue sequencer: captures fetched bundles, runs the data-memory
// handshake and gates the slot write enables and PC update strobe.
module issue_sequencer
  import issue_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int STALL_W     = 16
) (
  input logic               clk,
  input logic               rst,
  issue_sequencer_if.master bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [31:0]        bundle_q, bundle_d;
  logic               valid_q, valid_d;
  logic [7:0]         waitCnt_q, waitCnt_d;
  logic               loadPend_q, loadPend_d;
  logic [2:0]         loadRd_q, loadRd_d;
  logic               memErr_q, memErr_d;
  logic [STALL_W-1:0] stallCnt_q, stallCnt_d;

  logic    irReady, memReq, memWe, commit1, commit2, pcWrite, flush, timeoutNow;
  pc_src_e pcSrc;
  logic    loadUse, rdConflict;
  logic    slot1Live, isLd, isSt, isJmp, isBr;
  logic    [4:0] op1, op2;
  logic    unusedBits;

  assign op1        = bundle_q[OP1_LSB +: 5];
  assign op2        = bundle_q[OP2_LSB +: 5];
  assign slot1Live  = valid_q && ((op1 == OP1_ALU) || (op1 == OP1_ADDI));
  assign unusedBits = ^{bundle_q[BASE_LSB +: 3], bundle_q[OFFS_LSB +: 5],
                        bundle_q[15:12], bundle_q[8:5]};

  always_comb begin
    isLd  = 1'b0;
    isSt  = 1'b0;
    isJmp = 1'b0;
    isBr  = 1'b0;
    if (valid_q) begin
      case (op2)
        OP2_LD:  isLd  = 1'b1;
        OP2_ST:  isSt  = 1'b1;
        OP2_JMP: isJmp = 1'b1;
        OP2_BR:  isBr  = 1'b1;
        OP_NOP:  ;
        default: ;
      endcase
    end
  end

  issue_hazard_chk u_hazard (
    .loadPend_i  (loadPend_q),
    .loadRd_i    (loadRd_q),
    .incRs1_i    (bus.ir[RS1_LSB +: 3]),
    .incRs2_i    (bus.ir[RS2_LSB +: 3]),
    .op2_i       (op2),
    .rd1_i       (bundle_q[RD1_LSB +: 3]),
    .rd2_i       (bundle_q[RD2_LSB +: 3]),
    .loadUse_o   (loadUse),
    .rdConflict_o(rdConflict)
  );

  always_comb begin
    state_d    = state_q;
    bundle_d   = bundle_q;
    valid_d    = valid_q;
    waitCnt_d  = waitCnt_q;
    loadPend_d = loadPend_q;
    loadRd_d   = loadRd_q;
    memErr_d   = memErr_q;
    stallCnt_d = stallCnt_q;
    irReady    = 1'b0;
    memReq     = 1'b0;
    memWe      = 1'b0;
    commit1    = 1'b0;
    commit2    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = PC_NEXT;
    flush      = 1'b0;
    timeoutNow = 1'b0;

    unique case (state_q)
      ST_IDLE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (isLd || isSt) begin
          memReq    = 1'b1;
          memWe     = isSt;
          waitCnt_d = 8'd1;
          state_d   = ST_MEM_WAIT;
        end else begin
          irReady = 1'b1;
          if (valid_q) begin
            commit1 = slot1Live;
            commit2 = isJmp || isBr;
            pcWrite = 1'b1;
            if (isJmp) begin
              pcSrc = PC_JUMP;
              flush = 1'b1;
            end else if (isBr && bus.cond_true) begin
              pcSrc = PC_BRANCH;
              flush = 1'b1;
            end
          end
          valid_d = 1'b0;
          // A bundle accepted under a redirect is dropped and never bubbles
          if (bus.ir_valid) begin
            bundle_d   = bus.ir;
            valid_d    = !flush;
            loadPend_d = 1'b0;
            if (loadUse && !flush) state_d = ST_BUBBLE;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (waitCnt_q >= TIMEOUT_CNT) begin
          timeoutNow = 1'b1;
          memErr_d   = 1'b1;
          commit1    = 1'b1;
          pcWrite    = 1'b1;
          valid_d    = 1'b0;
          state_d    = ST_EXEC;
        end else begin
          memReq    = 1'b1;
          memWe     = isSt;
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      ST_BUBBLE: state_d = ST_EXEC;
      default:   state_d = ST_IDLE;
    endcase

    // Ack only counts while the request is actually driven; the load wins any rd clash
    if (memReq && bus.mem_ack) begin
      commit1 = slot1Live && !rdConflict;
      commit2 = isLd;
      pcWrite = 1'b1;
      valid_d = 1'b0;
      state_d = ST_EXEC;
      if (isLd) begin
        loadPend_d = 1'b1;
        loadRd_d   = bundle_q[RD2_LSB +: 3];
      end
    end

    if ((state_q != ST_IDLE) && !irReady && (stallCnt_q != '1))
      stallCnt_d = stallCnt_q + STALL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bundle_q   <= '0;
      valid_q    <= 1'b0;
      waitCnt_q  <= '0;
      loadPend_q <= 1'b0;
      loadRd_q   <= '0;
      memErr_q   <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bundle_q   <= bundle_d;
      valid_q    <= valid_d;
      waitCnt_q  <= waitCnt_d;
      loadPend_q <= loadPend_d;
      loadRd_q   <= loadRd_d;
      memErr_q   <= memErr_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign bus.ir_ready  = irReady;
  assign bus.mem_req   = memReq;
  assign bus.mem_we    = memWe;
  assign bus.commit1   = commit1;
  assign bus.commit2   = commit2;
  assign bus.pc_write  = pcWrite;
  assign bus.pc_src    = pcSrc;
  assign bus.flush     = flush;
  assign bus.mem_err   = memErr_q | timeoutNow;
  assign bus.stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_issue_sequencer.sv
// Directed self-checking bench for issue_sequencer: ALU stream, load/store
// handshakes, load-use bubble, redirects, timeout and mid-access reset.
module tb_issue_sequencer;

  localparam logic [4:0] ALU = 5'b01000;
  localparam logic [4:0] NOP = 5'b00000;
  localparam logic [4:0] LD  = 5'b01010;
  localparam logic [4:0] ST  = 5'b01011;
  localparam logic [4:0] JMP = 5'b11110;
  localparam logic [4:0] BR  = 5'b11011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;

  issue_sequencer_if #(.STALL_W(16)) bus ();

  issue_sequencer #(.MEM_TIMEOUT(15), .STALL_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] o1, input logic [2:0] d1,
                                     input logic [2:0] s1, input logic [2:0] s2,
                                     input logic [4:0] o2, input logic [2:0] d2);
    logic [31:0] b;
    b        = '0;
    b[4:0]   = o1;
    b[7:5]   = s2;
    b[11:9]  = d1;
    b[14:12] = s1;
    b[20:16] = o2;
    b[23:21] = d2;
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] b,
                               input logic cond, input logic ack);
    bus.ir_valid  = v;
    bus.ir        = b;
    bus.cond_true = cond;
    bus.mem_ack   = ack;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle after reset release, i.e. in the first EXEC cycle
  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("rst_ir_ready", bus.ir_ready, 0);
    checkOutput("rst_mem_req", bus.mem_req, 0);
    checkOutput("rst_pc_write", bus.pc_write, 0);
    checkOutput("rst_stall", bus.stall_cnt, 0);
    checkOutput("rst_mem_err", bus.mem_err, 0);
    rst = 1'b0;
    nextCycle();
    checkOutput("ready_after_rst", bus.ir_ready, 1);
  endtask

  initial begin
    resetDut();

    // Three back-to-back ALU bundles
    applyStimulus(1'b1, mk(ALU, 3'd1, 3'd2, 3'd3, NOP, 3'd0), 1'b0, 1'b0);
    checkOutput("alu_pre_commit1", bus.commit1, 0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      if (i < 2) applyStimulus(1'b1, mk(ALU, 3'(i + 2), 3'd2, 3'd3, NOP, 3'd0), 1'b0, 1'b0);
      else       applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("alu_commit1", bus.commit1, 1);
      checkOutput("alu_pc_write", bus.pc_write, 1);
      checkOutput("alu_ir_ready", bus.ir_ready, 1);
    end
    nextCycle();
    checkOutput("alu_drain_commit1", bus.commit1, 0);
    checkOutput("alu_stall", bus.stall_cnt, 0);

    // Load rd=3 acked in the fourth request cycle
    resetDut();
    applyStimulus(1'b1, mk(ALU, 3'd1, 3'd2, 3'd4, LD, 3'd3), 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("ld_req0", bus.mem_req, 1);
    checkOutput("ld_we", bus.mem_we, 0);
    checkOutput("ld_ready0", bus.ir_ready, 0);
    checkOutput("ld_commit2_0", bus.commit2, 0);
    nextCycle();
    checkOutput("ld_req1", bus.mem_req, 1);
    nextCycle();
    checkOutput("ld_req2", bus.mem_req, 1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("ld_req3", bus.mem_req, 1);
    checkOutput("ld_ack_commit1", bus.commit1, 1);
    checkOutput("ld_ack_commit2", bus.commit2, 1);
    checkOutput("ld_ack_pc_write", bus.pc_write, 1);
    nextCycle();
    applyStimulus(1'b1, mk(ALU, 3'd2, 3'd0, 3'd0, LD, 3'd2), 1'b0, 1'b0);
    checkOutput("ld_after_req", bus.mem_req, 0);
    checkOutput("ld_after_commit2", bus.commit2, 0);
    checkOutput("ld_stall", bus.stall_cnt, 4);
    // Same-rd load: slot-1 write suppressed, load still commits
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("conflict_commit1", bus.commit1, 0);
    checkOutput("conflict_commit2", bus.commit2, 1);

    // Load rd=5 then ALU reading r5: one bubble
    resetDut();
    applyStimulus(1'b1, mk(NOP, 3'd0, 3'd0, 3'd0, LD, 3'd5), 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("lu_req", bus.mem_req, 1);
    checkOutput("lu_commit2", bus.commit2, 1);
    checkOutput("lu_ready_ack", bus.ir_ready, 0);
    nextCycle();
    applyStimulus(1'b1, mk(ALU, 3'd6, 3'd5, 3'd0, NOP, 3'd0), 1'b0, 1'b0);
    checkOutput("lu_accept_ready", bus.ir_ready, 1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("bubble_ready", bus.ir_ready, 0);
    checkOutput("bubble_commit1", bus.commit1, 0);
    checkOutput("bubble_commit2", bus.commit2, 0);
    checkOutput("bubble_pc_write", bus.pc_write, 0);
    nextCycle();
    checkOutput("lu_commit1", bus.commit1, 1);
    checkOutput("lu_pc_write", bus.pc_write, 1);
    checkOutput("lu_stall", bus.stall_cnt, 2);

    // Taken branch, not-taken branch, then jump
    resetDut();
    applyStimulus(1'b1, mk(ALU, 3'd1, 3'd0, 3'd0, BR, 3'd0), 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, mk(ALU, 3'd2, 3'd0, 3'd0, NOP, 3'd0), 1'b1, 1'b0);
    checkOutput("brt_pc_src", bus.pc_src, 2'b01);
    checkOutput("brt_flush", bus.flush, 1);
    checkOutput("brt_pc_write", bus.pc_write, 1);
    checkOutput("brt_commit2", bus.commit2, 1);
    nextCycle();
    applyStimulus(1'b1, mk(ALU, 3'd1, 3'd0, 3'd0, BR, 3'd0), 1'b0, 1'b0);
    checkOutput("brt_flushed_commit1", bus.commit1, 0);
    checkOutput("brt_flushed_pc_write", bus.pc_write, 0);
    nextCycle();
    applyStimulus(1'b1, mk(ALU, 3'd2, 3'd0, 3'd0, NOP, 3'd0), 1'b0, 1'b0);
    checkOutput("brn_pc_src", bus.pc_src, 2'b00);
    checkOutput("brn_flush", bus.flush, 0);
    checkOutput("brn_pc_write", bus.pc_write, 1);
    nextCycle();
    applyStimulus(1'b1, mk(NOP, 3'd0, 3'd0, 3'd0, JMP, 3'd0), 1'b0, 1'b0);
    checkOutput("brn_next_commit1", bus.commit1, 1);
    nextCycle();
    applyStimulus(1'b1, mk(ALU, 3'd4, 3'd0, 3'd0, NOP, 3'd0), 1'b0, 1'b0);
    checkOutput("jmp_pc_src", bus.pc_src, 2'b10);
    checkOutput("jmp_flush", bus.flush, 1);
    checkOutput("jmp_commit1", bus.commit1, 0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("jmp_flushed_commit1", bus.commit1, 0);
    checkOutput("jmp_flushed_pc_write", bus.pc_write, 0);

    // Store never acked: 15 request cycles then timeout
    resetDut();
    applyStimulus(1'b1, mk(ALU, 3'd1, 3'd0, 3'd0, ST, 3'd2), 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("st_we", bus.mem_we, 1);
    for (int k = 0; k < 15; k++) begin
      checkOutput("st_req_held", bus.mem_req, 1);
      checkOutput("st_no_err", bus.mem_err, 0);
      nextCycle();
    end
    checkOutput("to_mem_req", bus.mem_req, 0);
    checkOutput("to_mem_err", bus.mem_err, 1);
    checkOutput("to_commit1", bus.commit1, 1);
    checkOutput("to_commit2", bus.commit2, 0);
    checkOutput("to_pc_write", bus.pc_write, 1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("late_ack_req", bus.mem_req, 0);
    checkOutput("late_ack_commit1", bus.commit1, 0);
    checkOutput("late_ack_pc_write", bus.pc_write, 0);
    checkOutput("late_ack_err", bus.mem_err, 1);
    checkOutput("to_stall", bus.stall_cnt, 16);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("err_sticky", bus.mem_err, 1);

    // Asynchronous reset in the middle of a memory wait
    applyStimulus(1'b1, mk(ALU, 3'd1, 3'd0, 3'd0, ST, 3'd2), 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("mw_req", bus.mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_mem_req", bus.mem_req, 0);
    checkOutput("arst_commit1", bus.commit1, 0);
    checkOutput("arst_commit2", bus.commit2, 0);
    checkOutput("arst_pc_write", bus.pc_write, 0);
    checkOutput("arst_stall", bus.stall_cnt, 0);
    checkOutput("arst_mem_err", bus.mem_err, 0);
    nextCycle();
    rst = 1'b0;
    nextCycle();
    checkOutput("arst_ready", bus.ir_ready, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
